fnd_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one 7-segment decoder (FND) and one segment bus among four common-anode digit positions. It holds a 4-digit BCD value from the up/down counter logic and rotates through the digits at a fixed rate. Each digit slot starts with a blanking dead-time to suppress ghosting. New values commit only at frame boundaries, so a displayed frame never tears. The block sits between the counter/LED logic and the FND decoder instance on the board top level.

---
 rtl/fnd_pkg.sv | 33 +++
 rtl/fnd_digit_sel.sv | 48 ++++
 rtl/fnd_scan_ctrl.sv | 115 +++++++++++
 tb/tb_fnd_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller.
//   NUM_DIGITS   : digit positions on the shared segment bus
//   BCD_MAX      : largest legal BCD code; larger codes are blanked
//   phase_e      : slot phase, BLANK dead-time or SHOW
//   bcd_lzb_mask : leading-zero blank mask of a 4-digit BCD value
package fnd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_e;

  // Bit k set when lzb is enabled and digits k..top are all zero.
  // Digit 0 is never zero-blanked, so bit 0 is always clear.
  function automatic logic [NUM_DIGITS-1:0] bcd_lzb_mask(
    input logic [4*NUM_DIGITS-1:0] val,
    input logic                    lzb
  );
    logic [NUM_DIGITS-1:0] mask;
    logic                  upper_zero;
    mask       = '0;
    upper_zero = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (val[4*k +: 4] == 4'd0);
      mask[k]    = lzb && upper_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/fnd_digit_sel.sv
// Combinational digit selector for the FND scan controller.
//   idx      : active slot index
//   phase    : BLANK or SHOW phase of the active slot
//   disp_val : committed 4-digit BCD value
//   disp_dp  : committed decimal points
//   disp_lzb : committed leading-zero blanking enable
//   digit    : one-hot digit enable, 0 when dark
//   bcd      : BCD code of the active digit, 0 when dark
//   dp       : decimal point of the active digit, 0 when dark
module fnd_digit_sel
  import fnd_pkg::*;
(
  input  logic [1:0]  idx,
  input  phase_e      phase,
  input  logic [15:0] disp_val,
  input  logic [3:0]  disp_dp,
  input  logic        disp_lzb,
  output logic [3:0]  digit,
  output logic [3:0]  bcd,
  output logic        dp
);

  logic [NUM_DIGITS-1:0] blank_mask;
  logic [3:0]            sel_bcd;

  always_comb begin
    blank_mask = bcd_lzb_mask(disp_val, disp_lzb);
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (disp_val[4*k +: 4] > BCD_MAX) begin
        blank_mask[k] = 1'b1;
      end
    end
  end

  assign sel_bcd = disp_val[{idx, 2'b00} +: 4];

  always_comb begin
    digit = '0;
    bcd   = '0;
    dp    = 1'b0;
    if ((phase == SHOW) && !blank_mask[idx]) begin
      digit = 4'b0001 << idx;
      bcd   = sel_bcd;
      dp    = disp_dp[idx];
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit common-anode FND scan controller.
// Rotates one shared BCD/segment bus across four digits, with a dark
// dead-time at the start of every slot. New values are held pending and
// only committed on the digit-3 to digit-0 wrap so a frame never tears.
//   i_Clk    : system clock, rising edge
//   i_Rst    : asynchronous active-high reset
//   i_Val    : four BCD digits, [3:0] is digit 0
//   i_Dp     : decimal-point request per digit
//   i_Load   : strobe capturing i_Val/i_Dp into the pending register
//   i_LZB    : leading-zero blanking enable, sampled at commit
//   o_Digit  : one-hot digit enable, 0 when all off
//   o_BCD    : BCD code of the active digit
//   o_DP     : decimal point of the active digit
//   o_Frame  : one-cycle pulse when a commit takes effect
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [15:0] i_Val,
  input  logic [3:0]  i_Dp,
  input  logic        i_Load,
  input  logic        i_LZB,
  output logic [3:0]  o_Digit,
  output logic [3:0]  o_BCD,
  output logic        o_DP,
  output logic        o_Frame
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      pend_val;
  logic [3:0]       pend_dp;
  logic             pend_flag;
  logic [15:0]      disp_val;
  logic [3:0]       disp_dp;
  logic             disp_lzb;

  phase_e           phase;
  logic             slot_end;
  logic             wrap;
  logic             commit;
  logic [3:0]       sel_digit;
  logic [3:0]       sel_bcd;
  logic             sel_dp;

  assign phase    = (cnt < CNT_W'(BLANK_CYC)) ? BLANK : SHOW;
  assign slot_end = (cnt == CNT_W'(CLK_DIV - 1));
  assign wrap     = slot_end && (idx == 2'd3);
  // A load coinciding with the wrap is committed directly, bypassing pending.
  assign commit   = wrap && (pend_flag || i_Load);

  fnd_digit_sel u_digit_sel (
    .idx      (idx),
    .phase    (phase),
    .disp_val (disp_val),
    .disp_dp  (disp_dp),
    .disp_lzb (disp_lzb),
    .digit    (sel_digit),
    .bcd      (sel_bcd),
    .dp       (sel_dp)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt       <= '0;
      idx       <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_val  <= '0;
      disp_dp   <= '0;
      disp_lzb  <= 1'b0;
      o_Digit   <= '0;
      o_BCD     <= '0;
      o_DP      <= 1'b0;
      o_Frame   <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (i_Load) begin
        pend_val <= i_Val;
        pend_dp  <= i_Dp;
      end

      if (wrap) begin
        pend_flag <= 1'b0;
      end else if (i_Load) begin
        pend_flag <= 1'b1;
      end

      if (commit) begin
        disp_val <= i_Load ? i_Val : pend_val;
        disp_dp  <= i_Load ? i_Dp  : pend_dp;
        disp_lzb <= i_LZB;
      end

      o_Frame <= commit;
      o_Digit <= sel_digit;
      o_BCD   <= sel_bcd;
      o_DP    <= sel_dp;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

  localparam int unsigned CLK_DIV   = 8;
  localparam int unsigned BLANK_CYC = 2;

  logic        i_Clk  = 1'b0;
  logic        i_Rst  = 1'b1;
  logic [15:0] i_Val  = '0;
  logic [3:0]  i_Dp   = '0;
  logic        i_Load = 1'b0;
  logic        i_LZB  = 1'b0;
  logic [3:0]  o_Digit;
  logic [3:0]  o_BCD;
  logic        o_DP;
  logic        o_Frame;

  fnd_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Val   (i_Val),
    .i_Dp    (i_Dp),
    .i_Load  (i_Load),
    .i_LZB   (i_LZB),
    .o_Digit (o_Digit),
    .o_BCD   (o_BCD),
    .o_DP    (o_DP),
    .o_Frame (o_Frame)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [3:0]  digit;
    logic [3:0]  bcd;
    logic        dp;
    int unsigned len;
  } slot_t;

  slot_t       exp_q[$];
  int unsigned frame_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned ecnt  = 0;

  // Rising edges since the last reset release.
  always @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic push_slot(input logic [3:0] d, input logic [3:0] b, input logic p,
                           input int unsigned len = 6);
    slot_t s;
    s.digit = d; s.bcd = b; s.dp = p; s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic push_zero_frame();
    push_slot(4'b0001, 4'h0, 1'b0); push_slot(4'b0010, 4'h0, 1'b0);
    push_slot(4'b0100, 4'h0, 1'b0); push_slot(4'b1000, 4'h0, 1'b0);
  endtask

  // Monitor: collapse each lit run into one record and compare it.
  logic [3:0]  run_digit = '0;
  logic [3:0]  run_bcd   = '0;
  logic        run_dp    = 1'b0;
  logic        run_bad   = 1'b0;
  int unsigned run_len   = 0;

  task automatic finish_run();
    slot_t e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL slot_unexpected: got digit %b bcd %0h len %0d, expected none", run_digit, run_bcd, run_len);
    end else begin
      e = exp_q.pop_front();
      check("slot_digit", run_digit, e.digit);
      check("slot_bcd", run_bcd, e.bcd);
      check("slot_dp", run_dp, e.dp);
      check("slot_len", run_len, e.len);
      check("slot_stable", run_bad, 0);
    end
    run_len = 0;
  endtask

  always @(negedge i_Clk) begin
    if (o_Frame) begin
      if (frame_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL frame_unexpected: got pulse at edge %0d, expected none", ecnt);
      end else begin
        check("frame_edge", ecnt, frame_q.pop_front());
      end
    end
    if (o_Digit == 4'd0) begin
      check("dark_bcd_dp", {o_BCD, o_DP}, 0);
      if (run_len > 0) finish_run();
    end else begin
      if (run_len > 0 && o_Digit != run_digit) finish_run();
      if (run_len == 0) begin
        run_digit = o_Digit; run_bcd = o_BCD; run_dp = o_DP; run_bad = 1'b0;
      end else if (o_BCD != run_bcd || o_DP != run_dp) begin
        run_bad = 1'b1;
      end
      run_len++;
    end
  end

  task automatic wait_edge(input int unsigned n);
    int unsigned guard = 0;
    while (ecnt != n) begin
      @(negedge i_Clk);
      guard++;
      if (guard > 2000) begin
        n_vec++; n_err++;
        $display("FAIL wait_timeout: got edge %0d, expected edge %0d", ecnt, n);
        return;
      end
    end
  endtask

  // Load captured on edge n; commit_edge=0 means no pulse expected from it.
  task automatic do_load(input int unsigned n, input logic [15:0] v, input logic [3:0] dp,
                         input logic lzb, input int unsigned commit_edge);
    wait_edge(n - 1);
    i_Val = v; i_Dp = dp; i_LZB = lzb; i_Load = 1'b1;
    @(negedge i_Clk);
    i_Load = 1'b0;
    if (commit_edge != 0) frame_q.push_back(commit_edge);
  endtask

  initial begin
    // F0..F2: idle, zeros
    push_zero_frame(); push_zero_frame(); push_zero_frame();
    // F3: 1234, dp on digit 1
    push_slot(4'b0001, 4'h4, 1'b0); push_slot(4'b0010, 4'h3, 1'b1);
    push_slot(4'b0100, 4'h2, 1'b0); push_slot(4'b1000, 4'h1, 1'b0);
    // F4: 0070 with leading-zero blanking
    push_slot(4'b0001, 4'h0, 1'b0); push_slot(4'b0010, 4'h7, 1'b0);
    // F5: 0070 without blanking
    push_slot(4'b0001, 4'h0, 1'b0); push_slot(4'b0010, 4'h7, 1'b0);
    push_slot(4'b0100, 4'h0, 1'b0); push_slot(4'b1000, 4'h0, 1'b0);
    // F6: 2222 (1111 overwritten)
    push_slot(4'b0001, 4'h2, 1'b0); push_slot(4'b0010, 4'h2, 1'b0);
    push_slot(4'b0100, 4'h2, 1'b0); push_slot(4'b1000, 4'h2, 1'b0);
    // F7, F8: 3333 with dp on digit 3
    for (int i = 0; i < 2; i++) begin
      push_slot(4'b0001, 4'h3, 1'b0); push_slot(4'b0010, 4'h3, 1'b0);
      push_slot(4'b0100, 4'h3, 1'b0); push_slot(4'b1000, 4'h3, 1'b1);
    end
    // F9: 9A05, digit 2 invalid
    push_slot(4'b0001, 4'h5, 1'b0); push_slot(4'b0010, 4'h0, 1'b0);
    push_slot(4'b1000, 4'h9, 1'b0);
    // F10: 1234 cut short by reset two cycles into digit 2
    push_slot(4'b0001, 4'h4, 1'b0); push_slot(4'b0010, 4'h3, 1'b0);
    push_slot(4'b0100, 4'h2, 1'b0, 2);

    repeat (3) @(negedge i_Clk);
    check("reset_digit", o_Digit, 0);
    check("reset_bcd", o_BCD, 0);
    check("reset_dp", o_DP, 0);
    check("reset_frame", o_Frame, 0);
    i_Rst = 1'b0;

    do_load(69,  16'h1234, 4'b0010, 1'b1 ^ 1'b1, 96);
    do_load(100, 16'h0070, 4'b0000, 1'b1, 128);
    do_load(140, 16'h0070, 4'b0000, 1'b0, 160);
    do_load(165, 16'h1111, 4'b0000, 1'b0, 0);
    do_load(170, 16'h2222, 4'b0000, 1'b0, 192);
    do_load(224, 16'h3333, 4'b1000, 1'b0, 224);
    do_load(260, 16'h9A05, 4'b0000, 1'b0, 288);
    do_load(300, 16'h1234, 4'b0000, 1'b0, 320);
    do_load(325, 16'h5555, 4'b1111, 1'b0, 0);

    // Asynchronous reset during the digit-2 SHOW phase, load pending.
    wait_edge(340);
    @(posedge i_Clk);
    #2 i_Rst = 1'b1;
    #1;
    check("midrst_digit", o_Digit, 0);
    check("midrst_bcd", o_BCD, 0);
    check("midrst_dp", o_DP, 0);
    check("midrst_frame", o_Frame, 0);
    repeat (3) @(negedge i_Clk);
    push_zero_frame(); push_zero_frame();
    i_Rst = 1'b0;

    wait_edge(66);
    @(negedge i_Clk);
    check("slots_left", exp_q.size(), 0);
    check("frames_left", frame_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
